// File: rtl/lsu_mem_requester.sv
// Load/store requester: accepts one request at a time, drives the memory port,
// splits misaligned half/word accesses into little-endian byte beats, assembles
// and extends load data, and returns a single-cycle response pulse.
module lsu_mem_requester #(
    parameter int MEM_RD_LATENCY   = 0,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_split,
    output logic        mem_wr_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_in_data,
    output logic [1:0]  mem_size,
    output logic        mem_sz_ex,
    input  logic [31:0] mem_out_data
);

    // Last wait count inside a load beat; the beat ends when wait_q reaches it.
    localparam logic [1:0] RD_WAIT = 2'(MEM_RD_LATENCY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q;

    // Request fields latched at accept.
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        split_q;
    logic [1:0]  last_beat_q;

    // Beat sequencing and load assembly.
    logic [1:0]  beat_q;
    logic [1:0]  wait_q;
    logic [31:0] asm_q;

    // Registered outputs.
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic        resp_split_q;
    logic        mem_wr_en_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_in_data_q;
    logic [1:0]  mem_size_q;
    logic        mem_sz_ex_q;

    // Classification of the incoming request.
    logic        misaligned_d;
    logic        err_d;
    logic        split_d;
    logic [1:0]  last_beat_d;

    // Memory-port values for the next beat to be issued.
    logic [1:0]  nb_k;
    logic [31:0] src_addr;
    logic [31:0] src_wdata;
    logic [1:0]  src_size;
    logic        src_uns;
    logic        src_split;
    logic        src_we;
    logic        nb_wr_en_d;
    logic [31:0] nb_address_d;
    logic [31:0] nb_in_data_d;
    logic [1:0]  nb_size_d;
    logic        nb_sz_ex_d;

    // Beat completion and load result.
    logic        beat_done;
    logic [31:0] asm_d;
    logic [31:0] load_result_d;

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign resp_split  = resp_split_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_address = mem_address_q;
    assign mem_in_data = mem_in_data_q;
    assign mem_size    = mem_size_q;
    assign mem_sz_ex   = mem_sz_ex_q;

    // Decide aligned / split / error and how many beats a request needs.
    always_comb begin
        misaligned_d = ((req_size == 2'b01) && req_addr[0])
                    || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        err_d        = (req_size == 2'b11) || (misaligned_d && !ALLOW_MISALIGNED);
        split_d      = misaligned_d && ALLOW_MISALIGNED && (req_size != 2'b11);
        last_beat_d  = split_d ? ((req_size == 2'b10) ? 2'd3 : 2'd1) : 2'd0;
    end

    // Memory-port drive for the next beat: beat 0 from the live request at accept,
    // later beats from the latched request.
    always_comb begin
        if (state_q == IDLE) begin
            src_addr  = req_addr;
            src_wdata = req_wdata;
            src_size  = req_size;
            src_uns   = req_unsigned;
            src_split = split_d;
            src_we    = req_we;
            nb_k      = 2'd0;
        end else begin
            src_addr  = addr_q;
            src_wdata = wdata_q;
            src_size  = size_q;
            src_uns   = unsigned_q;
            src_split = split_q;
            src_we    = we_q;
            nb_k      = beat_q + 2'd1;
        end
        nb_wr_en_d   = src_we;
        nb_address_d = src_addr + {30'd0, nb_k};
        if (src_split) begin
            nb_size_d    = 2'b00;
            nb_sz_ex_d   = 1'b0;
            nb_in_data_d = {24'd0, src_wdata[{nb_k, 3'b000} +: 8]};
        end else begin
            nb_size_d    = src_size;
            nb_sz_ex_d   = ~src_uns;
            nb_in_data_d = src_wdata;
        end
    end

    // Merge the current beat's read data and form the extended load result.
    always_comb begin
        beat_done = we_q || (wait_q == RD_WAIT);
        asm_d     = asm_q;
        if (split_q) begin
            asm_d[{beat_q, 3'b000} +: 8] = mem_out_data[7:0];
        end else begin
            asm_d = mem_out_data;
        end
        if (we_q) begin
            load_result_d = 32'd0;
        end else if (split_q && (size_q == 2'b01)) begin
            load_result_d = unsigned_q ? {16'd0, asm_d[15:0]}
                                       : {{16{asm_d[15]}}, asm_d[15:0]};
        end else begin
            load_result_d = asm_d;
        end
    end

    // Request FSM with registered memory-port and response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            size_q        <= 2'b00;
            unsigned_q    <= 1'b0;
            split_q       <= 1'b0;
            last_beat_q   <= 2'd0;
            beat_q        <= 2'd0;
            wait_q        <= 2'd0;
            asm_q         <= 32'd0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'd0;
            resp_err_q    <= 1'b0;
            resp_split_q  <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_address_q <= 32'd0;
            mem_in_data_q <= 32'd0;
            mem_size_q    <= 2'b00;
            mem_sz_ex_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        size_q      <= req_size;
                        unsigned_q  <= req_unsigned;
                        split_q     <= split_d;
                        last_beat_q <= last_beat_d;
                        beat_q      <= 2'd0;
                        wait_q      <= 2'd0;
                        asm_q       <= 32'd0;
                        req_ready_q <= 1'b0;
                        if (err_d) begin
                            // Errors never touch memory.
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_split_q <= 1'b0;
                            resp_rdata_q <= 32'd0;
                        end else begin
                            state_q       <= ACCESS;
                            mem_wr_en_q   <= nb_wr_en_d;
                            mem_address_q <= nb_address_d;
                            mem_in_data_q <= nb_in_data_d;
                            mem_size_q    <= nb_size_d;
                            mem_sz_ex_q   <= nb_sz_ex_d;
                        end
                    end
                end
                ACCESS: begin
                    if (beat_done) begin
                        asm_q <= asm_d;
                        if (beat_q == last_beat_q) begin
                            state_q       <= DONE;
                            resp_valid_q  <= 1'b1;
                            resp_err_q    <= 1'b0;
                            resp_split_q  <= split_q;
                            resp_rdata_q  <= load_result_d;
                            mem_wr_en_q   <= 1'b0;
                            mem_address_q <= 32'd0;
                            mem_in_data_q <= 32'd0;
                            mem_size_q    <= 2'b00;
                            mem_sz_ex_q   <= 1'b0;
                        end else begin
                            beat_q        <= beat_q + 2'd1;
                            wait_q        <= 2'd0;
                            mem_wr_en_q   <= nb_wr_en_d;
                            mem_address_q <= nb_address_d;
                            mem_in_data_q <= nb_in_data_d;
                            mem_size_q    <= nb_size_d;
                            mem_sz_ex_q   <= nb_sz_ex_d;
                        end
                    end else begin
                        // Hold the address stable until read data is valid.
                        wait_q <= wait_q + 2'd1;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_split_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_requester.sv
// Bench for lsu_mem_requester: u0 (read latency 1, split allowed) and u1
// (read latency 0, misaligned is an error) share one byte memory model.
module tb_lsu_mem_requester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v0, v1;
    logic        req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        r0_ready, r0_valid, r0_err, r0_split, m0_we, m0_sx;
    logic [31:0] r0_rdata, m0_addr, m0_wd, m0_rd;
    logic [1:0]  m0_size;
    logic        r1_ready, r1_valid, r1_err, r1_split, m1_we, m1_sx;
    logic [31:0] r1_rdata, m1_addr, m1_wd, m1_rd;
    logic [1:0]  m1_size;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mem [0:4095];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        split;
        int          due;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        int          due;
    } wr_t;

    resp_t q0[$];
    resp_t q1[$];
    wr_t   wq[$];

    lsu_mem_requester #(.MEM_RD_LATENCY(1), .ALLOW_MISALIGNED(1'b1)) u0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(r0_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(r0_valid), .resp_rdata(r0_rdata),
        .resp_err(r0_err), .resp_split(r0_split), .mem_wr_en(m0_we),
        .mem_address(m0_addr), .mem_in_data(m0_wd), .mem_size(m0_size),
        .mem_sz_ex(m0_sx), .mem_out_data(m0_rd)
    );

    lsu_mem_requester #(.MEM_RD_LATENCY(0), .ALLOW_MISALIGNED(1'b0)) u1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(r1_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(r1_valid), .resp_rdata(r1_rdata),
        .resp_err(r1_err), .resp_split(r1_split), .mem_wr_en(m1_we),
        .mem_address(m1_addr), .mem_in_data(m1_wd), .mem_size(m1_size),
        .mem_sz_ex(m1_sx), .mem_out_data(m1_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdfmt(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3,
                                          input logic [1:0] sz, input logic sx);
        case (sz)
            2'b00:   return sx ? {{24{b0[7]}}, b0} : {24'd0, b0};
            2'b01:   return sx ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
            2'b10:   return {b3, b2, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    // Memory read path: u0 sees data one cycle after the address, u1 immediately.
    logic [31:0] a0_d1;
    logic [1:0]  s0_d1;
    logic        x0_d1;
    always @(posedge clk) begin
        a0_d1 <= m0_addr;
        s0_d1 <= m0_size;
        x0_d1 <= m0_sx;
    end
    assign m0_rd = rdfmt(mem[a0_d1[11:0]], mem[a0_d1[11:0] + 12'd1],
                         mem[a0_d1[11:0] + 12'd2], mem[a0_d1[11:0] + 12'd3], s0_d1, x0_d1);
    assign m1_rd = rdfmt(mem[m1_addr[11:0]], mem[m1_addr[11:0] + 12'd1],
                         mem[m1_addr[11:0] + 12'd2], mem[m1_addr[11:0] + 12'd3], m1_size, m1_sx);

    // Memory write path plus write scoreboard; a write at a reset edge is dropped.
    always @(posedge clk) begin
        wr_t w;
        int  nbytes;
        cyc <= cyc + 1;
        if (rst && m0_we) begin
            nbytes = (m0_size == 2'b00) ? 1 : (m0_size == 2'b01) ? 2 : 4;
            for (int k = 0; k < 4; k++)
                if (k < nbytes) mem[m0_addr[11:0] + 12'(k)] <= m0_wd[8*k +: 8];
            if (wq.size() == 0) begin
                chk("u0_wr_unexpected", {31'd0, m0_we}, 32'd0);
            end else begin
                w = wq.pop_front();
                chk("u0_wr_addr", m0_addr, w.addr);
                chk("u0_wr_data", m0_wd, w.data);
                chk("u0_wr_size", {30'd0, m0_size}, {30'd0, w.size});
                chk("u0_wr_cycle", 32'(cyc), 32'(w.due));
            end
        end
        if (rst && m1_we) begin
            chk("u1_wr_unexpected", {31'd0, m1_we}, 32'd0);
        end
    end

    // Response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        resp_t e;
        if (r0_valid) begin
            if (q0.size() == 0) begin
                chk("u0_resp_unexpected", {31'd0, r0_valid}, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("u0_resp_rdata", r0_rdata, e.rdata);
                chk("u0_resp_err", {31'd0, r0_err}, {31'd0, e.err});
                chk("u0_resp_split", {31'd0, r0_split}, {31'd0, e.split});
                chk("u0_resp_cycle", 32'(cyc), 32'(e.due));
            end
        end
        if (r1_valid) begin
            if (q1.size() == 0) begin
                chk("u1_resp_unexpected", {31'd0, r1_valid}, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("u1_resp_rdata", r1_rdata, e.rdata);
                chk("u1_resp_err", {31'd0, r1_err}, {31'd0, e.err});
                chk("u1_resp_split", {31'd0, r1_split}, {31'd0, e.split});
                chk("u1_resp_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Drive one request (called at a negedge), wait for accept, push expectations,
    // then drop valid and scramble the request fields.
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                         input logic [31:0] exp_rdata, input bit push, output int acc);
        logic mis, err, split;
        int   n, nb, lat;
        wr_t  w;
        mis   = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
        err   = (size == 2'b11) || (mis && (d == 1));
        split = mis && !err;
        nb    = split ? ((size == 2'b10) ? 4 : 2) : 1;
        lat   = err ? 1 : (we ? 1 + nb : 1 + nb * ((d == 0) ? 2 : 1));
        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
        if (d == 0) v0 = 1'b1; else v1 = 1'b1;
        n = 0;
        while ((((d == 0) ? r0_ready : r1_ready) !== 1'b1) && (n < 64)) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait_bounded", {31'd0, (n < 64)}, 32'd1);
        acc = cyc;
        if (push) begin
            if (d == 0) q0.push_back('{exp_rdata, err, split, acc + lat});
            else        q1.push_back('{exp_rdata, err, split, acc + lat});
            if (we && !err) begin
                for (int k = 0; k < nb; k++) begin
                    if (split) w = '{addr + 32'(k), {24'd0, wdata[8*k +: 8]}, 2'b00, acc + 1 + k};
                    else       w = '{addr, wdata, size, acc + 1};
                    wq.push_back(w);
                end
            end
        end
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
        req_we = 1'($urandom); req_unsigned = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (((q0.size() != 0) || (q1.size() != 0) || (wq.size() != 0)) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bounded", {31'd0, (n < 100)}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int acc_a, acc_b, acc;
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_size = 2'b00; req_unsigned = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", {31'd0, r0_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, r0_valid}, 32'd0);
        chk("rst_mem_wr_en", {31'd0, m0_we}, 32'd0);
        chk("rst_mem_address", m0_addr, 32'd0);
        chk("rst_resp_rdata", r0_rdata, 32'd0);
        chk("rst_u1_req_ready", {31'd0, r1_ready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Aligned word store then load back.
        issue(0, 1'b1, 32'h0, 32'hFF00FF00, 2'b10, 1'b0, 32'h0, 1'b1, acc);
        drain();
        issue(0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'hFF00FF00, 1'b1, acc);
        drain();

        // Misaligned half store and signed split load at 0x81.
        issue(0, 1'b1, 32'h81, 32'h00FF00FF, 2'b01, 1'b0, 32'h0, 1'b1, acc);
        drain();
        issue(0, 1'b0, 32'h81, 32'h0, 2'b01, 1'b0, 32'h000000FF, 1'b1, acc);
        drain();

        // Misaligned word store across the address wrap, then split load.
        issue(0, 1'b1, 32'hFFFFFFFE, 32'h11223344, 2'b10, 1'b0, 32'h0, 1'b1, acc);
        drain();
        issue(0, 1'b0, 32'hFFFFFFFE, 32'h0, 2'b10, 1'b0, 32'h11223344, 1'b1, acc);
        drain();

        // Byte 0x80 at 0x24; signed and unsigned byte loads.
        issue(0, 1'b1, 32'h24, 32'h00000080, 2'b00, 1'b0, 32'h0, 1'b1, acc);
        drain();
        issue(0, 1'b0, 32'h24, 32'h0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b1, acc);
        chk("byte_signed_sz_ex", {31'd0, m0_sx}, 32'd1);
        chk("byte_signed_size", {30'd0, m0_size}, 32'd0);
        drain();
        issue(0, 1'b0, 32'h24, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b1, acc);
        chk("byte_unsigned_sz_ex", {31'd0, m0_sx}, 32'd0);
        drain();

        // Split half loads at 0x23 (bit 15 set): sign vs zero extension.
        issue(0, 1'b0, 32'h23, 32'h0, 2'b01, 1'b0, 32'hFFFF8000, 1'b1, acc);
        drain();
        issue(0, 1'b0, 32'h23, 32'h0, 2'b01, 1'b1, 32'h00008000, 1'b1, acc);
        drain();

        // Illegal size on u0.
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 1'b0, 32'h0, 1'b1, acc);
        drain();

        // u1: misaligned is an error; aligned load with zero read latency.
        issue(1, 1'b0, 32'h2, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, acc);
        drain();
        issue(1, 1'b1, 32'h1, 32'h0000ABCD, 2'b01, 1'b0, 32'h0, 1'b1, acc);
        drain();
        issue(1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'hFF001122, 1'b1, acc);
        drain();

        // Request held while busy is taken only once req_ready returns.
        issue(0, 1'b0, 32'hFFFFFFFE, 32'h0, 2'b10, 1'b0, 32'h11223344, 1'b1, acc_a);
        issue(0, 1'b0, 32'h24, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b1, acc_b);
        chk("busy_accept_cycle", 32'(acc_b), 32'(acc_a + 10));
        drain();

        // Reset during beat 1 of a misaligned word store.
        issue(0, 1'b1, 32'h41, 32'hAABBCCDD, 2'b10, 1'b0, 32'h0, 1'b0, acc);
        wq.push_back('{32'h41, 32'h000000DD, 2'b00, acc + 1});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_wr_en", {31'd0, m0_we}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, r0_ready}, 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_after_wr_en", {31'd0, m0_we}, 32'd0);
            chk("rst_after_resp_valid", {31'd0, r0_valid}, 32'd0);
        end
        chk("rst_beat1_not_written", {24'd0, mem[12'h42]}, 32'd0);
        chk("rst_beat0_written", {24'd0, mem[12'h41]}, 32'h000000DD);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
